// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - shares one pipelined booth multiplier among NUM_REQ requesters behind a credited response FIFO
// Build option: define MUL_ARB_FIXED_PRIO_EN for strict lowest-index priority; round-robin otherwise.

module mul_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  MUL_LAT    = 5,
  parameter int  FIFO_DEPTH = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [63:0]           mul_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_result
);

  localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] DEPTH_U = FIFO_DEPTH;
  localparam logic [31:0] NUM_U   = NUM_REQ;

  logic [ID_W-1:0]  grant_id;
  logic             grant_found;
  logic             accept;
  logic             credit_ok;
  logic [31:0]      inflight_count;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  logic [MUL_LAT:0] trk_v;
  logic [ID_W-1:0]  trk_id [MUL_LAT+1];

  logic [63:0]      fifo_res [FIFO_DEPTH];
  logic [ID_W-1:0]  fifo_id  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every accepted request owns one FIFO slot from acceptance until it is popped,
  // so counting in-flight plus queued entries makes overflow impossible.
  assign inflight_count = 32'($countones(trk_v));
  assign credit_ok      = (32'(fifo_count) + inflight_count) < DEPTH_U;

`ifdef MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] rr_idx;

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    rr_idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = ID_W'((32'(last_grant) + 32'(k)) % NUM_U);
      if (!grant_found && req_valid[rr_idx]) begin
        grant_found = 1'b1;
        grant_id    = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end
`endif

  assign accept = rstn && credit_ok && grant_found;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_ready[i] = accept;
        sel_a        = req_a[32*i +: 32];
        sel_b        = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      mul_a <= sel_a;
      mul_b <= sel_b;
    end
  end

  // One stage per cycle of multiplier latency plus the result-capture stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trk_v <= '0;
      for (int s = 0; s <= MUL_LAT; s++) begin
        trk_id[s] <= '0;
      end
    end else begin
      trk_v     <= {trk_v[MUL_LAT-1:0], accept};
      trk_id[0] <= grant_id;
      for (int s = 1; s <= MUL_LAT; s++) begin
        trk_id[s] <= trk_id[s-1];
      end
    end
  end

  assign push      = trk_v[MUL_LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_res[wr_ptr] <= mul_result;
      fifo_id[wr_ptr]  <= trk_id[MUL_LAT];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // Head is forced to zero when empty so reset and idle outputs read as 0.
  assign rsp_id     = rsp_valid ? fifo_id[rd_ptr]  : '0;
  assign rsp_result = rsp_valid ? fifo_res[rd_ptr] : '0;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - randomized and directed self-checking bench for mul_arbiter against a queue-based model
// Follows MUL_ARB_FIXED_PRIO_EN to select the expected arbitration rule.

module tb_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int MUL_LAT    = 5;
  localparam int FIFO_DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a = '0;
  logic [32*NUM_REQ-1:0] req_b = '0;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [63:0]           mul_result;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [63:0]           rsp_result;

  mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic longint smul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // Signed multiplier: operands captured at an edge appear on mul_result MUL_LAT edges later.
  longint pipe [MUL_LAT] = '{default: 0};
  always @(posedge clk) begin
    for (int s = MUL_LAT - 1; s > 0; s--) pipe[s] <= pipe[s-1];
    pipe[0] <= smul(mul_a, mul_b);
  end
  assign mul_result = pipe[MUL_LAT-1];

  typedef struct { int id; longint res; int t; } exp_t;
  exp_t               q[$];
  int                 outstanding = 0;
  int                 last_g = NUM_REQ - 1;
  int                 cyc = 0;
  logic [31:0]        ema = '0;
  logic [31:0]        emb = '0;
  logic [NUM_REQ-1:0] exp_ready = '0;
  logic [NUM_REQ-1:0] acc_mask = '0;
  logic               exp_rv = 1'b0;
  logic [63:0]        pop_log[$];

  // Expected grant: a slot is free while fewer than FIFO_DEPTH requests are accepted-but-unpopped.
  function automatic logic [NUM_REQ-1:0] model_grant(input logic [NUM_REQ-1:0] v, input int lg, input int outs);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (FIFO_DEPTH - outs <= 0) return r;
`ifdef MUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[i]) begin r[i] = 1'b1; return r; end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (lg + k) % NUM_REQ;
      if (v[idx]) begin r[idx] = 1'b1; return r; end
    end
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      outstanding = 0;
      last_g = NUM_REQ - 1;
      ema = '0;
      emb = '0;
      exp_ready = '0;
      exp_rv = 1'b0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_result", rsp_result, 64'd0);
    end else begin
      exp_ready = model_grant(req_valid, last_g, outstanding);
      exp_rv = (q.size() > 0) && (q[0].t <= cyc);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
        chk("rsp_result", rsp_result, q[0].res);
      end
      chk("mul_a", 64'(mul_a), 64'(ema));
      chk("mul_b", 64'(mul_b), 64'(emb));
    end
  end

  always @(posedge clk) begin
    cyc++;
    acc_mask = '0;
    if (rstn) begin
      if (rsp_valid && rsp_ready) pop_log.push_back(rsp_result);
      if (exp_rv && rsp_ready) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (exp_ready != '0) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (exp_ready[i]) begin
            q.push_back('{i, smul(req_a[32*i +: 32], req_b[32*i +: 32]), cyc + MUL_LAT + 1});
            outstanding++;
            last_g = i;
            ema = req_a[32*i +: 32];
            emb = req_b[32*i +: 32];
          end
        end
        acc_mask = exp_ready;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit got;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i] = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 50) begin
      step();
      n++;
      got = acc_mask[i];
    end
    chk("send_accepted", 64'(got), 64'd1);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc, nacc, pv, pr;
    bit found;
    int gseq [8];

    do_reset();

    // Lone request: 3*5 appears MUL_LAT+1 edges after its accept edge.
    rsp_ready = 1'b1;
    send(0, 32'd3, 32'd5);
    acc_cyc = cyc;
    found = 0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (rsp_valid) found = 1;
    end
    chk("p33_rsp_seen", 64'(found), 64'd1);
    chk("p33_latency", 64'(cyc - acc_cyc), 64'd6);
    chk("p33_rsp_id", 64'(rsp_id), 64'd0);
    chk("p33_rsp_result", rsp_result, 64'd15);
    step();

    // All four streaming: round-robin 0,1,2,3 repeating, one per cycle.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'hFFFF_FFFE;
    end
    req_valid = '1;
    pop_log.delete();
    for (int c = 0; c < 8; c++) begin
      step();
      gseq[c] = -1;
      for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) gseq[c] = i;
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) chk($sformatf("p34_grant%0d", c), 64'(gseq[c]), 64'(c % 4));
    repeat (15) step();
    chk("p34_pop_count", 64'(pop_log.size()), 64'd8);
    if (pop_log.size() >= 4) begin
      chk("p34_res0", pop_log[0], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("p34_res1", pop_log[1], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("p34_res2", pop_log[2], 64'hFFFF_FFFF_FFFF_FFFA);
      chk("p34_res3", pop_log[3], 64'hFFFF_FFFF_FFFF_FFF8);
    end

    // Consumer stalled: exactly FIFO_DEPTH accepts, then one pop frees one slot.
    rsp_ready = 1'b0;
    req_a[63:32] = $urandom;
    req_b[63:32] = $urandom;
    req_valid[1] = 1'b1;
    nacc = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (acc_mask[1]) begin
        nacc++;
        req_a[63:32] = $urandom;
        req_b[63:32] = $urandom;
      end
    end
    chk("p35_accepts", 64'(nacc), 64'd8);
    chk("p35_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    step();
    chk("p35_pop_edge_no_acc", 64'(acc_mask), 64'd0);
    rsp_ready = 1'b0;
    step();
    chk("p35_resume", 64'(acc_mask), 64'b0010);
    step();
    chk("p35_full_again", 64'(acc_mask), 64'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (20) step();

    // Signed corner operands.
    pop_log.delete();
    send(0, 32'h8000_0000, 32'h8000_0000);
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (12) step();
    chk("p36_pop_count", 64'(pop_log.size()), 64'd2);
    if (pop_log.size() >= 2) begin
      chk("p36_min_sq", pop_log[0], 64'h4000_0000_0000_0000);
      chk("p36_neg1_sq", pop_log[1], 64'h0000_0000_0000_0001);
    end

    // Reset with two queued and three in flight discards everything.
    rsp_ready = 1'b0;
    send(2, 32'd7, 32'd9);
    send(2, 32'd11, 32'd13);
    repeat (8) step();
    send(2, 32'd1, 32'd2);
    send(2, 32'd3, 32'd4);
    send(2, 32'd5, 32'd6);
    rstn = 1'b0;
    step();
    chk("p37_rsp_valid_in_rst", 64'(rsp_valid), 64'd0);
    step();
    rstn = 1'b1;
    pop_log.delete();
    rsp_ready = 1'b1;
    repeat (20) step();
    chk("p37_no_stale", 64'(pop_log.size()), 64'd0);
    chk("p37_rsp_valid_idle", 64'(rsp_valid), 64'd0);
    req_a[31:0] = 32'd21;  req_b[31:0] = 32'd2;
    req_a[127:96] = 32'd5; req_b[127:96] = 32'd5;
    req_valid = 4'b1001;
    step();
    chk("p37_first_grant", 64'(acc_mask), 64'b0001);
    req_valid[0] = 1'b0;
    step();
    chk("p37_second_grant", 64'(acc_mask), 64'b1000);
    req_valid = '0;
    repeat (12) step();

    // Randomized traffic across load and back-pressure mixes.
    for (int seg = 0; seg < 4; seg++) begin
      pv = (seg == 0) ? 90 : (seg == 1) ? 40 : (seg == 2) ? 100 : 20;
      pr = (seg == 0) ? 100 : (seg == 1) ? 50 : (seg == 2) ? 15 : 80;
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!req_valid[i] || acc_mask[i]) begin
            req_valid[i] = ($urandom_range(0, 99) < pv);
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
          end
        end
        rsp_ready = ($urandom_range(0, 99) < pr);
        step();
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (30) step();
    chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);

    // Two contenders held high: fixed priority starves req2, round-robin alternates.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      step();
`ifdef MUL_ARB_FIXED_PRIO_EN
      chk($sformatf("p38_prio%0d", c), 64'(acc_mask), 64'b0001);
`else
      chk($sformatf("p38_rr%0d", c), 64'(acc_mask), (c % 2 == 0) ? 64'b0001 : 64'b0100);
`endif
    end
    req_valid = '0;
    repeat (15) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
